// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encoding, transmitter states, data length decode.
package uart_pkg;

   localparam logic UART_IDLE_LVL = 1'b1;

   // 2'b11 is not listed and behaves as NONE
   typedef enum logic [1:0] {
      NONE = 2'b00,
      EVEN = 2'b01,
      ODD  = 2'b10
   } parity_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   // data_bits 00..11 -> 5..8 data bits per frame
   function automatic logic [3:0] data_len(input logic [1:0] data_bits);
      return 4'd5 + {2'b00, data_bits};
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable bit-period down-counter; bit_end_o marks the last clock of a bit.
module uart_baud_cnt #(
   parameter int DIV_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [DIV_W-1:0] load_val_i,
   output logic             bit_end_o
);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;

   // reload at every bit start, otherwise count down and rest at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // counter register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_end_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte handshake in, start/data/parity/stop frame out on tx_o.
//
// state  | meaning
// IDLE   | line at idle level, waiting for an accepted byte
// START  | driving the start bit (0)
// DATA   | shifting out len data bits, LSB first
// PARITY | driving the precomputed parity bit
// STOP   | driving 1 or 2 stop bits; last clock may accept the next byte
module uart_tx
   import uart_pkg::*;
#(
   parameter int DIV_W  = 16,
   parameter int DATA_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             tx_en_i,
   input  logic [DIV_W-1:0] baud_div_i,
   input  logic [1:0]       data_bits_i,
   input  logic [1:0]       parity_i,
   input  logic             stop2_i,
   input  logic [DATA_W-1:0] s_data_i,
   input  logic             s_valid_i,
   output logic             s_ready_o,
   output logic             tx_o,
   output logic             busy_o,
   output logic             tx_done_o
);

   if (DATA_W != 8) begin : g_data_w_chk
      $error("uart_tx: DATA_W must be 8");
   end

   tx_state_t        state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [3:0]       len_q, len_d;
   logic             par_en_q, par_en_d;
   logic             par_bit_q, par_bit_d;
   logic             stop2_q, stop2_d;
   logic [7:0]       shift_q, shift_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic             stop_cnt_q, stop_cnt_d;
   logic             tx_q, tx_d;

   logic             bit_end;
   logic             load;
   logic [DIV_W-1:0] load_val;
   logic             last_stop;
   logic             accept;
   logic [3:0]       len_in;
   logic [7:0]       data_mask;
   logic [7:0]       data_in;
   logic             par_in;
   parity_t          par_sel;

   uart_baud_cnt #(
      .DIV_W(DIV_W)
   ) u_baud_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (load),
      .load_val_i (load_val),
      .bit_end_o  (bit_end)
   );

   assign last_stop = (state_q == STOP) && bit_end && (stop_cnt_q == stop2_q);
   assign s_ready_o = !rst_i && tx_en_i && ((state_q == IDLE) || last_stop);
   assign accept    = s_valid_i && s_ready_o;
   assign busy_o    = (state_q != IDLE);
   assign tx_done_o = last_stop;
   assign tx_o      = tx_q;

   // frame format captured at accept; parity is settled up front so PARITY just replays it
   always_comb begin
      par_sel   = parity_t'(parity_i);
      len_in    = data_len(data_bits_i);
      data_mask = 8'hFF >> (4'd8 - len_in);
      data_in   = s_data_i & data_mask;
      par_in    = ^data_in;
   end

   // next-state, shifter and line level
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      len_d      = len_q;
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
      stop2_d    = stop2_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      tx_d       = tx_q;
      load       = 1'b0;
      load_val   = div_q;

      if (accept) begin
         state_d    = START;
         div_d      = baud_div_i;
         len_d      = len_in;
         par_en_d   = (par_sel == EVEN) || (par_sel == ODD);
         par_bit_d  = (par_sel == ODD) ? ~par_in : par_in;
         stop2_d    = stop2_i;
         shift_d    = data_in;
         bit_cnt_d  = '0;
         stop_cnt_d = 1'b0;
         tx_d       = 1'b0;
         load       = 1'b1;
         load_val   = baud_div_i;
      end else begin
         case (state_q)
            IDLE: begin
               tx_d = UART_IDLE_LVL;
            end
            START: begin
               if (bit_end) begin
                  state_d   = DATA;
                  tx_d      = shift_q[0];
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = '0;
                  load      = 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  load = 1'b1;
                  if (bit_cnt_q == 3'(len_q - 4'd1)) begin
                     if (par_en_q) begin
                        state_d = PARITY;
                        tx_d    = par_bit_q;
                     end else begin
                        state_d    = STOP;
                        tx_d       = UART_IDLE_LVL;
                        stop_cnt_d = 1'b0;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + 3'd1;
                     tx_d      = shift_q[0];
                     shift_d   = shift_q >> 1;
                  end
               end
            end
            PARITY: begin
               if (bit_end) begin
                  state_d    = STOP;
                  tx_d       = UART_IDLE_LVL;
                  stop_cnt_d = 1'b0;
                  load       = 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (stop_cnt_q == stop2_q) begin
                     state_d = IDLE;
                     tx_d    = UART_IDLE_LVL;
                  end else begin
                     stop_cnt_d = 1'b1;
                     load       = 1'b1;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               tx_d    = UART_IDLE_LVL;
            end
         endcase
      end
   end

   // state and datapath registers; line returns to idle level on reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         div_q      <= '0;
         len_q      <= '0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         stop2_q    <= 1'b0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         tx_q       <= UART_IDLE_LVL;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         len_q      <= len_d;
         par_en_q   <= par_en_d;
         par_bit_q  <= par_bit_d;
         stop2_q    <= stop2_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         tx_q       <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: per-clock line model (queue of expected levels) plus directed literal frames.
module tb_uart_tx;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        tx_en_i;
   logic [15:0] baud_div_i;
   logic [1:0]  data_bits_i;
   logic [1:0]  parity_i;
   logic        stop2_i;
   logic [7:0]  s_data_i;
   logic        s_valid_i;
   logic        s_ready_o;
   logic        tx_o;
   logic        busy_o;
   logic        tx_done_o;

   int n_tot  = 0;
   int n_pass = 0;
   int n_acc  = 0;

   typedef struct packed {
      logic lvl;
      logic last;
   } elem_t;

   elem_t q[$];

   uart_tx #(.DIV_W(16), .DATA_W(8)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .tx_en_i     (tx_en_i),
      .baud_div_i  (baud_div_i),
      .data_bits_i (data_bits_i),
      .parity_i    (parity_i),
      .stop2_i     (stop2_i),
      .s_data_i    (s_data_i),
      .s_valid_i   (s_valid_i),
      .s_ready_o   (s_ready_o),
      .tx_o        (tx_o),
      .busy_o      (busy_o),
      .tx_done_o   (tx_done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // expand one frame into per-clock expected line levels
   task automatic push_frame(input int div, input int dbits, input int par,
                             input bit stop2, input bit [7:0] d);
      bit bits[$];
      int len;
      bit p;
      len = 5 + dbits;
      p = 1'b0;
      bits.push_back(1'b0);
      for (int i = 0; i < len; i++) begin
         bits.push_back(d[i]);
         p ^= d[i];
      end
      if (par == 1) bits.push_back(p);
      else if (par == 2) bits.push_back(!p);
      bits.push_back(1'b1);
      if (stop2) bits.push_back(1'b1);
      foreach (bits[i]) begin
         for (int k = 0; k <= div; k++) q.push_back('{lvl: bits[i], last: 1'b0});
      end
      q[q.size()-1].last = 1'b1;
   endtask

   // model: an edge consumes one expected clock and may start a new frame
   always @(posedge clk_i) begin
      bit acc;
      if (rst_i) begin
         q.delete();
      end else begin
         acc = s_valid_i && tx_en_i && (q.size() == 0 || q[0].last);
         if (q.size() > 0) void'(q.pop_front());
         if (acc) begin
            push_frame(int'(baud_div_i), int'(data_bits_i), int'(parity_i), stop2_i, s_data_i);
            n_acc++;
         end
      end
   end

   // compare every cycle against the model
   always @(negedge clk_i) begin
      logic e_tx, e_busy, e_done, e_rdy;
      if (rst_i) begin
         e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_rdy = 1'b0;
      end else if (q.size() == 0) begin
         e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_rdy = tx_en_i;
      end else begin
         e_tx = q[0].lvl; e_busy = 1'b1; e_done = q[0].last; e_rdy = tx_en_i && q[0].last;
      end
      chk("m_tx", 32'(tx_o), 32'(e_tx));
      chk("m_busy", 32'(busy_o), 32'(e_busy));
      chk("m_done", 32'(tx_done_o), 32'(e_done));
      chk("m_ready", 32'(s_ready_o), 32'(e_rdy));
   end

   task automatic tick();
      @(negedge clk_i);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy_o || q.size() != 0) && n < 400) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 400) chk("idle_timeout", 32'(busy_o), 32'd0);
      #1;
   endtask

   // directed single frame against a hand-written bit sequence (bit 0 goes first)
   task automatic run_frame(input string name, input int div, input logic [1:0] dbits,
                            input logic [1:0] par, input logic stop2, input logic [7:0] d,
                            input logic [11:0] exp_bits, input int nbits);
      int total;
      wait_idle();
      tx_en_i = 1'b1; baud_div_i = 16'(div); data_bits_i = dbits;
      parity_i = par; stop2_i = stop2; s_data_i = d; s_valid_i = 1'b1;
      total = nbits * (div + 1);
      for (int c = 1; c <= total + 1; c++) begin
         @(negedge clk_i);
         if (c <= total) begin
            chk({name, "_tx"}, 32'(tx_o), 32'(exp_bits[(c-1)/(div+1)]));
            chk({name, "_done"}, 32'(tx_done_o), 32'(c == total));
         end else begin
            chk({name, "_idle_after"}, 32'(busy_o), 32'd0);
         end
         #1;
         s_valid_i = 1'b0;
         baud_div_i = 16'($urandom_range(0, 7));
         data_bits_i = 2'($urandom);
         parity_i = 2'($urandom);
         stop2_i = 1'($urandom);
      end
   endtask

   initial begin
      int dones, gaps, acc0, n;
      logic [7:0] b2b [3];
      rst_i = 1'b1; tx_en_i = 1'b1; baud_div_i = '0; data_bits_i = 2'b11;
      parity_i = 2'b00; stop2_i = 1'b0; s_data_i = '0; s_valid_i = 1'b0;

      // reset and idle
      repeat (2) @(negedge clk_i);
      chk("rst_ready", 32'(s_ready_o), 32'd0);
      chk("rst_tx", 32'(tx_o), 32'd1);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      chk("idle_tx", 32'(tx_o), 32'd1);
      chk("idle_busy", 32'(busy_o), 32'd0);
      chk("idle_ready", 32'(s_ready_o), 32'd1);
      chk("idle_done", 32'(tx_done_o), 32'd0);
      repeat (4) tick();

      run_frame("8n1_55", 3, 2'b11, 2'b00, 1'b0, 8'h55, 12'b0010_1010_1010, 10);
      run_frame("7e2_83", 0, 2'b10, 2'b01, 1'b1, 8'h83, 12'b0110_0000_0110, 11);
      run_frame("5o1_ff", 1, 2'b00, 2'b10, 1'b0, 8'hFF, 12'b0000_1011_1110, 8);
      run_frame("par11_none", 0, 2'b00, 2'b11, 1'b0, 8'h0B, 12'b0000_0101_0110, 7);

      // back-to-back frames with valid held high
      wait_idle();
      b2b[0] = 8'h11; b2b[1] = 8'hC3; b2b[2] = 8'h7E;
      tx_en_i = 1'b1; baud_div_i = 16'd1; data_bits_i = 2'b11; parity_i = 2'b00; stop2_i = 1'b0;
      s_data_i = b2b[0]; s_valid_i = 1'b1;
      acc0 = n_acc; dones = 0; gaps = 0; n = 0;
      while (dones < 3 && n < 200) begin
         @(negedge clk_i);
         n++;
         if (tx_done_o) dones++;
         if (!busy_o) gaps++;
         #1;
         if (n_acc - acc0 >= 3) s_valid_i = 1'b0;
         else s_data_i = b2b[n_acc - acc0];
      end
      s_valid_i = 1'b0;
      chk("b2b_dones", 32'(dones), 32'd3);
      chk("b2b_gaps", 32'(gaps), 32'd0);
      chk("b2b_accepts", 32'(n_acc - acc0), 32'd3);

      // reset in the middle of the data bits
      wait_idle();
      tx_en_i = 1'b1; baud_div_i = 16'd3; data_bits_i = 2'b11; parity_i = 2'b00; stop2_i = 1'b0;
      s_data_i = 8'h3C; s_valid_i = 1'b1;
      @(negedge clk_i);
      #1 s_valid_i = 1'b0;
      repeat (9) @(negedge clk_i);
      chk("mid_data_bit1", 32'(tx_o), 32'd0);
      #2 rst_i = 1'b1;
      #1;
      chk("async_rst_tx", 32'(tx_o), 32'd1);
      chk("async_rst_busy", 32'(busy_o), 32'd0);
      repeat (2) @(negedge clk_i);
      #1 rst_i = 1'b0;
      run_frame("a5_after_rst", 2, 2'b11, 2'b00, 1'b0, 8'hA5, 12'b0011_0100_1010, 10);

      // randomized traffic with config churn mid-frame
      for (int i = 0; i < 6000; i++) begin
         tick();
         tx_en_i = ($urandom_range(0, 7) != 0);
         s_valid_i = ($urandom_range(0, 2) != 0);
         s_data_i = 8'($urandom);
         baud_div_i = 16'($urandom_range(0, 4));
         data_bits_i = 2'($urandom);
         parity_i = 2'($urandom);
         stop2_i = 1'($urandom);
      end
      s_valid_i = 1'b0;
      wait_idle();
      chk("random_accepts_seen", 32'(n_acc > 20), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
